// File: rtl/peak_meter_if.sv
// Bus bundle for peak_meter: Avalon-MM control slave plus Avalon-ST sink/source pass-through.
// The master modport is the side that drives the register bus and the sample stream.
interface peak_meter_if #(
    parameter int A_WDT = 16
);
    logic [1:0]              avs_address;
    logic                    avs_write;
    logic [31:0]             avs_writedata;
    logic                    avs_read;
    logic [31:0]             avs_readdata;
    logic                    asi_valid;
    logic signed [A_WDT-1:0] asi_data;
    logic                    aso_valid;
    logic signed [A_WDT-1:0] aso_data;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata,
        output asi_valid, asi_data,
        input  aso_valid, aso_data
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata,
        input  asi_valid, asi_data,
        output aso_valid, aso_data
    );
endinterface

// File: rtl/peak_meter.sv
// Windowed peak-magnitude meter on an Avalon-ST stream, with an Avalon-MM register map.
// Optional clip counter at address 3 is built only when PEAK_METER_CLIP_CNT_EN is defined.
module peak_meter #(
    parameter int A_WDT   = 16,
    parameter int WIN_WDT = 16
) (
    input  logic          csi_clk,
    input  logic          rsi_reset_n,
    peak_meter_if.slave   bus
);
    localparam int M_WDT = A_WDT - 1;
    localparam logic [M_WDT-1:0]         MAG_MAX = '1;
    localparam logic signed [A_WDT-1:0]  S_MIN   = {1'b1, {(A_WDT-1){1'b0}}};
    localparam logic signed [A_WDT-1:0]  S_MAX   = {1'b0, {(A_WDT-1){1'b1}}};
    localparam logic [WIN_WDT-1:0]       WIN_ONE = 1;
    localparam logic [1:0] ADDR_WINDOW  = 2'd0;
    localparam logic [1:0] ADDR_PEAK    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CLIPCNT = 2'd3;

    logic                    aso_valid_reg;
    logic signed [A_WDT-1:0] aso_data_reg;
    logic [WIN_WDT-1:0]      window_reg;
    logic [WIN_WDT-1:0]      cnt_reg;
    logic [M_WDT-1:0]        acc_reg;
    logic [M_WDT-1:0]        peak_reg;
    logic                    flag_reg;
    logic [31:0]             readdata_reg;

    logic signed [A_WDT-1:0] neg_data;
    logic [M_WDT-1:0]        mag;
    logic [M_WDT-1:0]        peak_cand;
    logic                    win_wr;
    logic                    peak_rd;
    logic                    sample_en;
    logic                    win_end;
    logic [31:0]             rd_mux;
    logic                    unused_wdata;

    assign neg_data = -bus.asi_data;

    // The most negative sample has no positive twin, so it saturates to full scale.
    always_comb begin
        mag = bus.asi_data[M_WDT-1:0];
        if (bus.asi_data == S_MIN) begin
            mag = MAG_MAX;
        end else if (bus.asi_data[A_WDT-1]) begin
            mag = neg_data[M_WDT-1:0];
        end
    end

    assign peak_cand = (mag > acc_reg) ? mag : acc_reg;
    assign win_wr    = bus.avs_write && (bus.avs_address == ADDR_WINDOW);
    assign peak_rd   = bus.avs_read  && (bus.avs_address == ADDR_PEAK);
    assign sample_en = bus.asi_valid && (window_reg != '0) && !win_wr;
    assign win_end   = sample_en && (cnt_reg == window_reg - WIN_ONE);

    assign unused_wdata = ^(bus.avs_writedata >> WIN_WDT);

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            aso_valid_reg <= 1'b0;
            aso_data_reg  <= '0;
        end else begin
            aso_valid_reg <= bus.asi_valid;
            aso_data_reg  <= bus.asi_data;
        end
    end

    // A WINDOW write restarts the window and swallows any sample arriving with it.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            window_reg <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            peak_reg   <= '0;
        end else if (win_wr) begin
            window_reg <= bus.avs_writedata[WIN_WDT-1:0];
            cnt_reg    <= '0;
            acc_reg    <= '0;
        end else if (win_end) begin
            peak_reg   <= peak_cand;
            cnt_reg    <= '0;
            acc_reg    <= '0;
        end else if (sample_en) begin
            cnt_reg    <= cnt_reg + WIN_ONE;
            acc_reg    <= peak_cand;
        end
    end

    // Window end wins over the clearing read so a fresh peak is never lost.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            flag_reg <= 1'b0;
        end else if (win_end) begin
            flag_reg <= 1'b1;
        end else if (peak_rd) begin
            flag_reg <= 1'b0;
        end
    end

`ifdef PEAK_METER_CLIP_CNT_EN
    logic [31:0] clip_cnt_reg;
    logic        clip_hit;
    logic        clip_clr;

    assign clip_hit = bus.asi_valid && ((bus.asi_data == S_MAX) || (bus.asi_data == S_MIN));
    assign clip_clr = bus.avs_write && (bus.avs_address == ADDR_CLIPCNT);

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            clip_cnt_reg <= '0;
        end else if (clip_clr) begin
            clip_cnt_reg <= '0;
        end else if (clip_hit && (clip_cnt_reg != '1)) begin
            clip_cnt_reg <= clip_cnt_reg + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.avs_address)
            ADDR_WINDOW:  rd_mux = 32'(window_reg);
            ADDR_PEAK:    rd_mux = 32'(peak_reg);
            ADDR_STATUS:  rd_mux = {31'd0, flag_reg};
`ifdef PEAK_METER_CLIP_CNT_EN
            ADDR_CLIPCNT: rd_mux = clip_cnt_reg;
`else
            ADDR_CLIPCNT: rd_mux = '0;
`endif
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            readdata_reg <= '0;
        end else if (bus.avs_read) begin
            readdata_reg <= rd_mux;
        end
    end

    assign bus.aso_valid    = aso_valid_reg;
    assign bus.aso_data     = aso_data_reg;
    assign bus.avs_readdata = readdata_reg;
endmodule

// File: tb/tb_peak_meter.sv
// Scoreboard bench for peak_meter: expected stream samples and read data are queued at drive
// time and popped when the DUT produces them; one line is printed per comparison.
module tb_peak_meter;
    localparam int A_WDT   = 16;
    localparam int WIN_WDT = 16;

`ifdef PEAK_METER_CLIP_CNT_EN
    localparam logic [31:0] CLIP1 = 32'd1;
    localparam logic [31:0] CLIP2 = 32'd2;
`else
    localparam logic [31:0] CLIP1 = 32'd0;
    localparam logic [31:0] CLIP2 = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic signed [A_WDT-1:0] aso_q[$];
    logic [31:0]             rd_q[$];

    peak_meter_if #(.A_WDT(A_WDT)) bus ();

    peak_meter #(.A_WDT(A_WDT), .WIN_WDT(WIN_WDT)) dut (
        .csi_clk     (clk),
        .rsi_reset_n (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic step(input logic v, input logic signed [A_WDT-1:0] d, input logic rd,
                        input logic [1:0] a, input logic wr, input logic [31:0] wd,
                        input logic [31:0] rexp, input string tag);
        logic signed [A_WDT-1:0] e_s;
        logic [31:0]             e_r;
        bus.asi_valid     = v;
        bus.asi_data      = d;
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_address   = a;
        bus.avs_writedata = wd;
        if (v)  aso_q.push_back(d);
        if (rd) rd_q.push_back(rexp);
        @(posedge clk);
        #1;
        check({tag, ":aso_valid"}, 32'(bus.aso_valid), 32'(v));
        if (bus.aso_valid) begin
            if (aso_q.size() == 0) begin
                check({tag, ":aso_q_empty"}, 32'd1, 32'd0);
            end else begin
                e_s = aso_q.pop_front();
                check({tag, ":aso_data"}, {16'd0, bus.aso_data}, {16'd0, e_s});
            end
        end
        if (rd) begin
            e_r = rd_q.pop_front();
            check(tag, bus.avs_readdata, e_r);
        end
    endtask

    task automatic smp(input logic signed [A_WDT-1:0] d);
        step(1'b1, d, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, "smp");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        step(1'b0, 16'sh55aa, 1'b1, a, 1'b0, 32'd0, exp, tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        step(1'b0, 16'sh0000, 1'b0, a, 1'b1, data, 32'd0, "wr");
    endtask

    initial begin
        bus.asi_valid     = 1'b0;
        bus.asi_data      = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_address   = 2'd0;
        bus.avs_writedata = 32'd0;

        // Reset state
        #12;
        check("rst_aso_valid", 32'(bus.aso_valid), 32'd0);
        check("rst_aso_data", {16'd0, bus.aso_data}, 32'd0);
        check("rst_readdata", bus.avs_readdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd0, 32'd0, "rst_window");
        rd(2'd1, 32'd0, "rst_peak");
        rd(2'd2, 32'd0, "rst_status");
        rd(2'd3, 32'd0, "rst_clipcnt");

        // WINDOW = 4, samples 100 -300 200 50
        wr(2'd0, 32'd4);
        rd(2'd0, 32'd4, "window4");
        smp(16'sd100);
        smp(-16'sd300);
        smp(16'sd200);
        rd(2'd2, 32'd0, "status_mid4");
        smp(16'sd50);
        rd(2'd2, 32'd1, "status_end4");
        rd(2'd1, 32'd300, "peak4");
        rd(2'd2, 32'd0, "status_clr4");

        // Saturation and clip counting
        wr(2'd0, 32'd1);
        smp(-16'sd32768);
        rd(2'd1, 32'd32767, "peak_min");
        rd(2'd3, CLIP1, "clip1");
        smp(16'sd32767);
        rd(2'd3, CLIP2, "clip2");
        step(1'b1, 16'sd32767, 1'b0, 2'd3, 1'b1, 32'd0, 32'd0, "clip_clr_wr");
        rd(2'd3, 32'd0, "clip_clr");
        wr(2'd1, 32'd5);
        rd(2'd1, 32'd32767, "peak_ro");
        rd(2'd2, 32'd0, "status_after_rd");

        // WINDOW = 3 with gaps in valid; invalid data is junk and must be ignored
        wr(2'd0, 32'd3);
        smp(16'sd10);
        step(1'b0, 16'sd30000, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, "gap");
        step(1'b0, -16'sd31000, 1'b1, 2'd2, 1'b0, 32'd0, 32'd0, "status_gap");
        smp(16'sd20);
        step(1'b0, 16'sd12345, 1'b1, 2'd2, 1'b0, 32'd0, 32'd0, "status_w2");
        smp(16'sd5);
        rd(2'd2, 32'd1, "status_w3");
        rd(2'd1, 32'd20, "peak_gaps");

        // PEAK read coinciding with a window end
        wr(2'd0, 32'd1);
        smp(16'sd7);
        rd(2'd1, 32'd7, "peak7");
        step(1'b1, -16'sd9, 1'b1, 2'd1, 1'b0, 32'd0, 32'd7, "peak_coinc");
        rd(2'd2, 32'd1, "flag_coinc");
        rd(2'd1, 32'd9, "peak9");
        rd(2'd2, 32'd0, "flag_clr9");

        // WINDOW rewrite mid-window discards earlier samples and the coincident one
        wr(2'd0, 32'd8);
        smp(16'sd1000);
        smp(16'sd900);
        smp(16'sd800);
        step(1'b1, 16'sd2000, 1'b0, 2'd0, 1'b1, 32'd2, 32'd0, "win_wr2");
        rd(2'd0, 32'd2, "window2");
        smp(16'sd40);
        rd(2'd2, 32'd0, "status_w2_mid");
        smp(-16'sd60);
        rd(2'd2, 32'd1, "status_w2_end");
        rd(2'd1, 32'd60, "peak_rewin");

        // WINDOW = 0 disables metering
        wr(2'd0, 32'd0);
        smp(16'sd500);
        smp(16'sd500);
        rd(2'd1, 32'd60, "peak_disabled");
        rd(2'd2, 32'd0, "flag_disabled");

        // Asynchronous reset mid-window
        wr(2'd0, 32'd4);
        smp(16'sd500);
        smp(16'sd1);
        smp(16'sd2);
        smp(16'sd3);
        smp(16'sd100);
        step(1'b1, 16'sd100, 1'b1, 2'd1, 1'b0, 32'd0, 32'd500, "peak500");
        #1;
        rst_n = 1'b0;
        bus.asi_valid = 1'b0;
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        #1;
        check("arst_aso_valid", 32'(bus.aso_valid), 32'd0);
        check("arst_aso_data", {16'd0, bus.aso_data}, 32'd0);
        check("arst_readdata", bus.avs_readdata, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd0, 32'd0, "arst_window");
        rd(2'd1, 32'd0, "arst_peak");
        rd(2'd2, 32'd0, "arst_status");
        rd(2'd3, 32'd0, "arst_clipcnt");
        wr(2'd0, 32'd2);
        smp(16'sd3);
        smp(-16'sd4);
        rd(2'd1, 32'd4, "peak_after_rst");

        check("aso_q_drain", 32'(aso_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/peak_meter.md
PEAK_METER -- requirements
Module: peak_meter

Interface
REQ-001 SHALL have parameter A_WDT, default 16, meaning sample width in sfi(A_WDT, A_WDT-1) format.
REQ-002 SHALL have parameter WIN_WDT, default 16, range 1..32, meaning width of the window-length register.
REQ-003 SHALL have port csi_clk, input, 1 bit, meaning the single clock.
REQ-004 SHALL have port rsi_reset_n, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port avs_address, input, 2 bits, meaning register select.
REQ-006 SHALL have ports avs_write (input, 1 bit) and avs_writedata (input, 32 bits), meaning Avalon-MM write strobe and data.
REQ-007 SHALL have ports avs_read (input, 1 bit) and avs_readdata (output, 32 bits), meaning Avalon-MM read strobe and data, with read latency 1.
REQ-008 SHALL have ports asi_valid (input, 1 bit) and asi_data (input, signed A_WDT bits), meaning the Avalon-ST sink fed by the upstream gain stage.
REQ-009 SHALL have ports aso_valid (output, 1 bit) and aso_data (output, signed A_WDT bits), meaning the Avalon-ST source pass-through.

Function
REQ-010 SHALL register asi_valid and asi_data to aso_valid and aso_data with exactly 1 cycle latency and no modification.
REQ-011 SHALL compute mag = |asi_data|, saturating -2^(A_WDT-1) to 2^(A_WDT-1)-1; mag is A_WDT-1 bits unsigned.
REQ-012 SHALL implement register map: addr0 WINDOW (RW, bits WIN_WDT-1:0); addr1 PEAK (RO, zero-extended mag); addr2 STATUS (RO, bit0 = new-peak flag); addr3 CLIPCNT (see REQ-022).
REQ-013 SHALL define window length as WINDOW samples; WINDOW = 0 disables metering (counter and accumulator held, PEAK and flag unchanged).
REQ-014 SHALL, for each asi_valid = 1 cycle with WINDOW > 0 and cnt < WINDOW-1, set acc <= max(acc, mag) and cnt <= cnt+1.
REQ-015 SHALL, on an asi_valid = 1 cycle with cnt = WINDOW-1 (window end), set PEAK <= max(acc, mag), acc <= 0, cnt <= 0, flag <= 1; WINDOW = 1 makes every valid sample a window end.
REQ-016 SHALL ignore samples on cycles with asi_valid = 0; the counter counts valid samples, not cycles.
REQ-017 SHALL, on a write to WINDOW, load the new value and clear cnt and acc on the next edge; a sample valid in the same cycle is discarded; PEAK and flag are retained.
REQ-018 SHALL clear the flag on a read of PEAK; if a window end coincides with that read, the flag SHALL end up 1 and the readdata SHALL return the old PEAK.
REQ-019 SHALL drive avs_readdata the cycle after avs_read, hold it until the next read, and return 0 for unused bits and for unmapped or disabled addresses.
REQ-020 SHALL ignore writes to read-only addresses.

Reset
REQ-021 SHALL, while rsi_reset_n = 0, asynchronously force aso_valid = 0, aso_data = 0, avs_readdata = 0, WINDOW = 0, PEAK = 0, acc = 0, cnt = 0, flag = 0 and CLIPCNT = 0; reset mid-window SHALL discard the partial window.

Configuration
REQ-022 SHALL, with macro PEAK_METER_CLIP_CNT_EN defined, implement CLIPCNT at addr3: a 32-bit count of valid samples equal to 2^(A_WDT-1)-1 or -2^(A_WDT-1), counted regardless of WINDOW, saturating at 2^32-1, cleared by any write to addr3 (a write in the same cycle as a clip sample SHALL leave CLIPCNT = 0).
REQ-023 SHALL, without PEAK_METER_CLIP_CNT_EN, contain no clip-counter logic; addr3 SHALL read 0 and writes to it SHALL be ignored.

Verification
REQ-024 SHALL verify: WINDOW = 4, samples 100, -300, 200, 50 -> PEAK = 300, flag = 1 after the 4th sample; aso_data equals each sample 1 cycle later.
REQ-025 SHALL verify: A_WDT = 16, WINDOW = 1, sample -32768 -> PEAK = 32767; with the macro defined, CLIPCNT = 1.
REQ-026 SHALL verify: WINDOW = 3, valid pattern 1,0,0,1,0,1 with samples 10, x, x, 20, x, 5 -> a single window end with PEAK = 20.
REQ-027 SHALL verify: a PEAK read in the same cycle as a window end (old PEAK = 7, new PEAK = 9) -> readdata = 7, flag = 1, the next read returns 9 and clears the flag.
REQ-028 SHALL verify: a WINDOW write of 2 after 3 samples of a WINDOW = 8 window -> the prior samples are discarded and the next 2 samples produce PEAK from those samples only.
REQ-029 SHALL verify: rsi_reset_n pulsed low mid-window with PEAK = 500 -> all outputs and registers read 0 immediately, without waiting for a clock edge.
